// File: rtl/imem_dumper.sv
// imem_dumper
// Reads instruction RAM from address 0 upward and writes each byte into the
// UART TX FIFO. After the last byte it writes one checksum byte. The checksum
// is chosen so that all bytes sent, checksum included, add up to 0x00 mod 256.
// The host uses this stream to verify a download.
//
// Ports
//   i_clk          system clock, rising edge
//   i_rst          synchronous reset, active-high
//   i_prog_en      programmer owns RAM/FIFO; blocks starts, aborts a dump
//   i_dump_start   one-cycle start pulse, honoured only when idle
//   i_dump_len     byte count, sampled with an accepted start
//   i_abort        cancels a dump in progress
//   o_mem_rd_en    RAM read strobe
//   o_mem_addr     RAM byte address
//   i_mem_rd_data  RAM read data, valid one cycle after o_mem_rd_en
//   i_tx_ff_full   TX FIFO full
//   o_tx_wr_en     TX FIFO write strobe
//   o_tx_data      TX byte, 0x00 whenever o_tx_wr_en is low
//   o_busy         dump in progress
//   o_done         one-cycle pulse after the checksum byte is written
//
// state | meaning
// IDLE  | waiting for a start
// READ  | read strobe for r_addr
// WAIT  | RAM data arrives, captured into r_byte
// PUSH  | write r_byte to the FIFO (holds while full)
// CSUM  | write the checksum byte (holds while full)
// DONE  | done pulse, back to IDLE
module imem_dumper #(
    parameter int MEM_SIZE = 32767
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_prog_en,
    input  logic        i_dump_start,
    input  logic [31:0] i_dump_len,
    input  logic        i_abort,
    output logic        o_mem_rd_en,
    output logic [31:0] o_mem_addr,
    input  logic [7:0]  i_mem_rd_data,
    input  logic        i_tx_ff_full,
    output logic        o_tx_wr_en,
    output logic [7:0]  o_tx_data,
    output logic        o_busy,
    output logic        o_done
);

    localparam logic [31:0] LP_MEM_SIZE = 32'(MEM_SIZE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_PUSH,
        S_CSUM,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_addr;
    logic [31:0] r_len;
    logic [7:0]  r_byte;
    logic [7:0]  r_sum;

    logic        w_start;
    logic        w_push;
    logic [31:0] w_clamped_len;
    logic        w_mem_rd_en;
    logic        w_tx_wr_en;
    logic [7:0]  w_tx_data;
    logic        w_done;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_start       = 1'b0;
        w_push        = 1'b0;
        w_mem_rd_en   = 1'b0;
        w_tx_wr_en    = 1'b0;
        w_tx_data     = 8'h00;
        w_done        = 1'b0;
        w_clamped_len = (i_dump_len > LP_MEM_SIZE) ? LP_MEM_SIZE : i_dump_len;

        case (r_state)
            S_IDLE: begin
                if (i_dump_start && !i_prog_en && !i_abort) begin
                    w_start = 1'b1;
                    w_next  = (w_clamped_len == 32'd0) ? S_CSUM : S_READ;
                end
            end
            S_READ: begin
                w_mem_rd_en = 1'b1;
                w_next      = S_WAIT;
            end
            S_WAIT: begin
                w_next = S_PUSH;
            end
            S_PUSH: begin
                if (!i_tx_ff_full) begin
                    w_tx_wr_en = 1'b1;
                    w_tx_data  = r_byte;
                    w_push     = 1'b1;
                    w_next     = (r_addr + 32'd1 == r_len) ? S_CSUM : S_READ;
                end
            end
            S_CSUM: begin
                if (!i_tx_ff_full) begin
                    w_tx_wr_en = 1'b1;
                    w_tx_data  = ~r_sum + 8'd1;
                    w_next     = S_DONE;
                end
            end
            S_DONE: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase

        // The programmer or an abort takes the shared ports back right away.
        // A byte written in this same cycle has already reached the FIFO.
        if ((r_state != S_IDLE) && (i_prog_en || i_abort)) begin
            w_next = S_IDLE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_addr <= 32'd0;
            r_len  <= 32'd0;
            r_byte <= 8'h00;
            r_sum  <= 8'h00;
        end else begin
            if (w_start) begin
                r_len  <= w_clamped_len;
                r_addr <= 32'd0;
                r_sum  <= 8'h00;
            end
            if (r_state == S_WAIT) begin
                r_byte <= i_mem_rd_data;
            end
            if (w_push) begin
                r_sum  <= r_sum + r_byte;
                r_addr <= r_addr + 32'd1;
            end
        end
    end

    assign o_mem_rd_en = w_mem_rd_en;
    assign o_mem_addr  = r_addr;
    assign o_tx_wr_en  = w_tx_wr_en;
    assign o_tx_data   = w_tx_data;
    assign o_done      = w_done;
    assign o_busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_imem_dumper.sv
// Directed bench for imem_dumper (built with MEM_SIZE = 8 to exercise the clamp).
// Cycle numbers are counted from the cycle in which dump_start is high (cycle 0).
module tb_imem_dumper;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        prog_en = 1'b0;
    logic        dump_start = 1'b0;
    logic [31:0] dump_len = 32'd0;
    logic        abort = 1'b0;
    logic        mem_rd_en;
    logic [31:0] mem_addr;
    logic [7:0]  mem_rd_data = 8'h00;
    logic        tx_ff_full = 1'b0;
    logic        tx_wr_en;
    logic [7:0]  tx_data;
    logic        busy;
    logic        done;

    imem_dumper #(.MEM_SIZE(8)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_prog_en    (prog_en),
        .i_dump_start (dump_start),
        .i_dump_len   (dump_len),
        .i_abort      (abort),
        .o_mem_rd_en  (mem_rd_en),
        .o_mem_addr   (mem_addr),
        .i_mem_rd_data(mem_rd_data),
        .i_tx_ff_full (tx_ff_full),
        .o_tx_wr_en   (tx_wr_en),
        .o_tx_data    (tx_data),
        .o_busy       (busy),
        .o_done       (done)
    );

    always #5 clk = ~clk;

    // RAM model, one-cycle read latency
    logic [7:0] ram [0:255];
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= ram[mem_addr[7:0]];
    end

    int cyc = 0;
    int t0 = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0]  tx_b [$];
    int          tx_t [$];
    int          done_t [$];
    logic [31:0] rd_a [$];
    int          bad_idle = 0;

    always @(negedge clk) begin
        if (tx_wr_en) begin
            tx_b.push_back(tx_data);
            tx_t.push_back(cyc - t0);
        end else if (tx_data !== 8'h00) begin
            bad_idle++;
        end
        if (done) done_t.push_back(cyc - t0);
        if (mem_rd_en) rd_a.push_back(mem_addr);
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else n_pass++;
    endtask

    logic        s_busy, s_rd, s_wr, s_done;
    logic [31:0] s_addr;
    logic [7:0]  s_data;

    // Issue one start, then run n_cyc further cycles driving the per-cycle events.
    task automatic run(input logic [31:0] len, input int n_cyc, input int prog_at,
                       input int rst_at, input int dup_at, input int f_lo1, input int f_hi1,
                       input int f_lo2, input int f_hi2, input int snap_at);
        tx_b.delete(); tx_t.delete(); done_t.delete(); rd_a.delete();
        @(posedge clk); #1;
        dump_len = len;
        dump_start = 1'b1;
        t0 = cyc;
        for (int rel = 1; rel <= n_cyc; rel++) begin
            @(posedge clk); #1;
            dump_start = (rel == dup_at);
            tx_ff_full = (rel >= f_lo1 && rel <= f_hi1) || (rel >= f_lo2 && rel <= f_hi2);
            prog_en    = (prog_at >= 0) && (rel >= prog_at);
            rst        = (rel == rst_at);
            if (rel == snap_at) begin
                #1;
                s_busy = busy; s_rd = mem_rd_en; s_wr = tx_wr_en;
                s_done = done; s_addr = mem_addr; s_data = tx_data;
            end
        end
        dump_start = 1'b0;
        tx_ff_full = 1'b0;
        rst = 1'b0;
    endtask

    function automatic logic [7:0] txb(input int i);
        return (i < tx_b.size()) ? tx_b[i] : 8'hxx;
    endfunction
    function automatic int txt(input int i);
        return (i < tx_t.size()) ? tx_t[i] : -1;
    endfunction

    // Four-byte image 01..04: checksum F6, checks bytes, timing and addresses.
    task automatic check_4byte(input string tag, input int tp[5], input int td);
        logic [7:0] eb [5];
        eb = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hF6};
        chk({tag, " count"}, tx_b.size(), 5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("%s byte%0d", tag, i), txb(i), eb[i]);
            chk($sformatf("%s time%0d", tag, i), txt(i), tp[i]);
        end
        chk({tag, " done cnt"}, done_t.size(), 1);
        chk({tag, " done t"}, (done_t.size() > 0) ? done_t[0] : -1, td);
        chk({tag, " rd cnt"}, rd_a.size(), 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("%s addr%0d", tag, i), (i < rd_a.size()) ? rd_a[i] : 32'hx, i);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 8'(i + 1);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst busy", busy, 0);
        chk("rst rd_en", mem_rd_en, 0);
        chk("rst wr_en", tx_wr_en, 0);
        chk("rst addr", mem_addr, 0);
        chk("rst data", tx_data, 0);
        chk("rst done", done, 0);
        rst = 1'b0;

        // Plain 4-byte dump: pushes at 3,6,9,12, checksum 13, done 14, idle 15
        run(32'd4, 20, -1, -1, -1, -1, -1, -1, -1, 15);
        check_4byte("plain", '{3, 6, 9, 12, 13}, 14);
        chk("plain busy end", s_busy, 0);

        // Backpressure: 5 stall cycles in first PUSH, 2 in CSUM
        run(32'd4, 26, -1, -1, -1, 3, 7, 18, 19, -1);
        check_4byte("bp", '{8, 11, 14, 17, 20}, 21);

        // Empty dump: only the checksum 0x00
        run(32'd0, 6, -1, -1, -1, -1, -1, -1, -1, -1);
        chk("empty count", tx_b.size(), 1);
        chk("empty byte", txb(0), 8'h00);
        chk("empty time", txt(0), 1);
        chk("empty rd", rd_a.size(), 0);
        chk("empty done t", (done_t.size() > 0) ? done_t[0] : -1, 2);

        // Abort via progEn after two bytes (pushed at 3 and 6)
        run(32'd100, 15, 7, -1, -1, -1, -1, -1, -1, 8);
        chk("abort count", tx_b.size(), 2);
        chk("abort byte1", txb(1), 8'h02);
        chk("abort done", done_t.size(), 0);
        chk("abort busy", s_busy, 0);
        chk("abort wr_en", s_wr, 0);
        prog_en = 1'b0;
        run(32'd4, 20, -1, -1, -1, -1, -1, -1, -1, -1);
        check_4byte("restart", '{3, 6, 9, 12, 13}, 14);

        // Clamp to MEM_SIZE=8 with all-FF image; a start pulse mid-dump is ignored
        for (int i = 0; i < 256; i++) ram[i] = 8'hFF;
        run(32'hFFFF_FFFF, 35, -1, -1, 10, -1, -1, -1, -1, -1);
        chk("clamp count", tx_b.size(), 9);
        chk("clamp byte0", txb(0), 8'hFF);
        chk("clamp byte7", txb(7), 8'hFF);
        chk("clamp csum", txb(8), 8'h08);
        chk("clamp csum t", txt(8), 25);
        chk("clamp done t", (done_t.size() > 0) ? done_t[0] : -1, 26);
        chk("clamp done cnt", done_t.size(), 1);
        chk("clamp rd cnt", rd_a.size(), 8);
        chk("clamp last addr", (rd_a.size() > 7) ? rd_a[7] : 32'hx, 7);

        // Synchronous reset asserted during the first PUSH
        for (int i = 0; i < 256; i++) ram[i] = 8'(i + 1);
        run(32'd4, 10, -1, 3, -1, -1, -1, -1, -1, 4);
        chk("rstmid busy", s_busy, 0);
        chk("rstmid rd_en", s_rd, 0);
        chk("rstmid wr_en", s_wr, 0);
        chk("rstmid addr", s_addr, 0);
        chk("rstmid data", s_data, 0);
        chk("rstmid done", s_done, 0);
        chk("rstmid count", tx_b.size(), 1);
        chk("rstmid done cnt", done_t.size(), 0);

        chk("idle data zero", bad_idle, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
